// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage: icodes, ALU functions, condition codes,
// stat codes, register sentinel, the CC record and the condition evaluator.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_fun_t;

  localparam logic [3:0] F_MULQ = 4'h4;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] R_NONE = 4'hF;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_RUN,
    MUL_DONE
  } mul_state_t;

  function automatic logic cond_eval(input cc_t cc, input logic [3:0] ifun);
    logic lt;
    lt = cc.sf ^ cc.of;
    case (ifun)
      C_YES:   cond_eval = 1'b1;
      C_LE:    cond_eval = lt | cc.zf;
      C_L:     cond_eval = lt;
      C_E:     cond_eval = cc.zf;
      C_NE:    cond_eval = ~cc.zf;
      C_GE:    cond_eval = ~lt;
      C_G:     cond_eval = ~lt & ~cc.zf;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic stat_ok(input logic [3:0] s);
    return !(s inside {S_HLT, S_ADR, S_INS});
  endfunction

endpackage

// File: rtl/y86_alu.sv
// Execute-stage ALU: operand selection from icode, function select, 64-bit result and flags.
module y86_alu
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic [1:0]  ifun,
  input  logic [63:0] val_a,
  input  logic [63:0] val_b,
  input  logic [63:0] val_c,
  output logic [63:0] result,
  output cc_t         flags
);

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  alu_fun_t    fun;

  always_comb begin
    alu_a = '0;
    case (icode)
      I_RRMOVQ, I_OPQ:              alu_a = val_a;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = val_c;
      I_CALL, I_PUSHQ:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:                alu_a = 64'd8;
      I_HALT, I_NOP, I_JXX:         alu_a = '0;
      default:                      alu_a = '0;
    endcase

    alu_b = '0;
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = val_b;
      default:                                                   alu_b = '0;
    endcase

    fun = (icode == I_OPQ) ? alu_fun_t'(ifun) : ALU_ADD;

    result = '0;
    flags  = '0;
    case (fun)
      ALU_ADD: begin
        result   = alu_b + alu_a;
        flags.of = (alu_a[63] == alu_b[63]) && (result[63] != alu_a[63]);
      end
      ALU_SUB: begin
        result   = alu_b - alu_a;
        flags.of = (alu_a[63] != alu_b[63]) && (result[63] != alu_b[63]);
      end
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
      default: result = '0;
    endcase
    flags.zf = (result == '0);
    flags.sf = result[63];
  end

endmodule

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition-code register, jXX/cmovXX condition and cmov dstE squash.
// Optional EXEC_MUL_EN adds a multi-cycle shift-add mulq (OPq ifun 4) that stalls via e_busy.
module execute_stage
  import y86_pkg::*;
`ifdef EXEC_MUL_EN
#(
  parameter int unsigned MUL_CYCLES = 64
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [63:0] E_valC,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  output logic [63:0] e_valE,
  output logic        e_Cnd,
  output logic [3:0]  e_dstE,
  output logic        e_busy
);

  cc_t         cc;
  cc_t         cc_next;
  logic        cc_load;
  logic [63:0] alu_res;
  cc_t         alu_flags;
  logic        opq;
  logic        writes_ok;

  logic unused_e_fields;
  assign unused_e_fields = ^{E_stat, E_dstM};

  y86_alu u_alu (
    .icode  (E_icode),
    .ifun   (E_ifun[1:0]),
    .val_a  (E_valA),
    .val_b  (E_valB),
    .val_c  (E_valC),
    .result (alu_res),
    .flags  (alu_flags)
  );

  assign opq       = (E_icode == I_OPQ);
  assign writes_ok = stat_ok(m_stat) && stat_ok(W_stat);

  always_comb begin
    e_Cnd = 1'b0;
    if (E_icode == I_RRMOVQ || E_icode == I_JXX) e_Cnd = cond_eval(cc, E_ifun);
    e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? R_NONE : E_dstE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cc <= CC_RESET;
    else if (cc_load) cc <= cc_next;
  end

`ifdef EXEC_MUL_EN
  localparam int unsigned CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_t     mul_state;
  mul_state_t     mul_state_next;
  logic           busy_c;
  logic           is_mul;
  logic [63:0]    mcand;
  logic [63:0]    mplier;
  logic [63:0]    acc;
  logic [CNT_W-1:0] cnt;

  assign is_mul = opq && (E_ifun == F_MULQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mul_state <= MUL_IDLE;
    else        mul_state <= mul_state_next;
  end

  always_comb begin
    mul_state_next = mul_state;
    busy_c         = 1'b0;
    case (mul_state)
      MUL_IDLE: if (is_mul) begin
        busy_c         = 1'b1;
        mul_state_next = MUL_RUN;
      end
      MUL_RUN: begin
        busy_c = 1'b1;
        if (cnt == CNT_LAST) mul_state_next = MUL_DONE;
      end
      MUL_DONE: mul_state_next = MUL_IDLE;
      default:  mul_state_next = MUL_IDLE;
    endcase
  end

  // Gated with rst_n so a reset drops the stall at once even while E still holds mulq.
  assign e_busy = rst_n & busy_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      case (mul_state)
        MUL_IDLE: if (is_mul) begin
          mcand  <= E_valB;
          mplier <= E_valA;
          acc    <= '0;
          cnt    <= '0;
        end
        MUL_RUN: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= {mcand[62:0], 1'b0};
          mplier <= {1'b0, mplier[63:1]};
          cnt    <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    e_valE  = alu_res;
    cc_load = 1'b0;
    cc_next = alu_flags;
    if (is_mul) begin
      e_valE = '0;
      if (mul_state == MUL_DONE) begin
        e_valE  = acc;
        cc_load = writes_ok;
        cc_next = '{zf: (acc == '0), sf: acc[63], of: 1'b0};
      end
    end else if (opq) begin
      if (E_ifun < F_MULQ) cc_load = writes_ok;
      else                 e_valE  = '0;
    end
  end
`else
  assign e_busy = 1'b0;

  always_comb begin
    e_valE  = alu_res;
    cc_load = 1'b0;
    cc_next = alu_flags;
    if (opq) begin
      if (E_ifun < F_MULQ) cc_load = writes_ok;
      else                 e_valE  = '0;
    end
  end
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized instructions against
// an arithmetic reference model of the result, flags and condition rules.
module tb_execute_stage;
  import y86_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
  logic [63:0] E_valA, E_valB, E_valC;
  logic [63:0] e_valE;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic        e_busy;

  int checks = 0;
  int errors = 0;

  bit m_zf = 1'b1;
  bit m_sf = 1'b0;
  bit m_of = 1'b0;

  execute_stage dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .E_stat  (E_stat),
    .E_icode (E_icode),
    .E_ifun  (E_ifun),
    .E_valA  (E_valA),
    .E_valB  (E_valB),
    .E_valC  (E_valC),
    .E_dstE  (E_dstE),
    .E_dstM  (E_dstM),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .e_valE  (e_valE),
    .e_Cnd   (e_Cnd),
    .e_dstE  (e_dstE),
    .e_busy  (e_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_cond(input logic [3:0] f);
    bit less;
    less = m_sf ^ m_of;
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return less || m_zf;
      4'd2:    return less;
      4'd3:    return m_zf;
      4'd4:    return !m_zf;
      4'd5:    return !less;
      4'd6:    return !less && !m_zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One instruction through E: drive at negedge, check mid-cycle, advance model CC at the edge.
  task automatic step(input logic [3:0] ic, input logic [3:0] f, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                      input logic [3:0] ms, input logic [3:0] ws);
    logic [63:0]        exp_v;
    logic               exp_c;
    logic [3:0]         exp_d;
    logic               ld;
    logic signed [64:0] wide;
    bit                 n_of;
    @(negedge clk);
    E_icode = ic; E_ifun = f; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = 4'($urandom); E_stat = 4'($urandom_range(1, 4));
    m_stat = ms; W_stat = ws;
    #1;
    exp_v = '0; ld = 1'b0; n_of = 1'b0;
    case (ic)
      I_RRMOVQ:           exp_v = a;
      I_IRMOVQ:           exp_v = c;
      I_RMMOVQ, I_MRMOVQ: exp_v = b + c;
      I_CALL, I_PUSHQ:    exp_v = b - 64'd8;
      I_RET, I_POPQ:      exp_v = b + 64'd8;
      I_OPQ: begin
        if (f <= 4'd3) begin
          ld = stat_ok(ms) && stat_ok(ws);
          case (f)
            4'd0: begin
              wide  = $signed({b[63], b}) + $signed({a[63], a});
              exp_v = wide[63:0];
              n_of  = (wide != $signed({wide[63], wide[63:0]}));
            end
            4'd1: begin
              wide  = $signed({b[63], b}) - $signed({a[63], a});
              exp_v = wide[63:0];
              n_of  = (wide != $signed({wide[63], wide[63:0]}));
            end
            4'd2:    exp_v = b & a;
            default: exp_v = b ^ a;
          endcase
        end
      end
      default: exp_v = '0;
    endcase
    exp_c = (ic == I_RRMOVQ || ic == I_JXX) ? m_cond(f) : 1'b0;
    exp_d = (ic == I_RRMOVQ && !exp_c) ? 4'hF : de;
    chk($sformatf("valE ic=%0h f=%0h", ic, f), e_valE, exp_v);
    chk($sformatf("Cnd ic=%0h f=%0h", ic, f), 64'(e_Cnd), 64'(exp_c));
    chk($sformatf("dstE ic=%0h f=%0h", ic, f), 64'(e_dstE), 64'(exp_d));
    chk($sformatf("busy ic=%0h f=%0h", ic, f), 64'(e_busy), 64'd0);
    @(posedge clk);
    if (ld) begin
      m_zf = (exp_v == 64'd0);
      m_sf = ($signed(exp_v) < 0);
      m_of = n_of;
    end
  endtask

  task automatic probe_cc();
    for (int f = 0; f < 7; f++)
      step(I_JXX, 4'(f), rnd64(), rnd64(), rnd64(), 4'(f), S_AOK, S_AOK);
  endtask

  initial begin
    logic [3:0]  ic, f, ms, ws;
    logic [63:0] a, b;
`ifdef EXEC_MUL_EN
    int          busy_n;
    int          guard;
    logic [63:0] exp_prod;
`endif

    rst_n = 1'b0;
    E_stat = S_AOK; E_icode = I_NOP; E_ifun = '0; E_valA = '0; E_valB = '0; E_valC = '0;
    E_dstE = 4'hF; E_dstM = 4'hF; m_stat = S_AOK; W_stat = S_AOK;
    #12;
    chk("reset busy", 64'(e_busy), 64'd0);
    chk("reset Cnd nop", 64'(e_Cnd), 64'd0);
    chk("reset valE nop", e_valE, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    probe_cc();

    step(I_OPQ, 4'd0, 64'd5, 64'd7, rnd64(), 4'd2, S_AOK, S_AOK);
    #1 chk("add 5+7", e_valE, 64'd12);
    probe_cc();

    step(I_OPQ, 4'd1, 64'd1, 64'h8000_0000_0000_0000, rnd64(), 4'd2, S_AOK, S_AOK);
    #1 chk("sub overflow", e_valE, 64'h7FFF_FFFF_FFFF_FFFF);
    probe_cc();

    step(I_OPQ, 4'd0, 64'd5, 64'd7, rnd64(), 4'd2, S_AOK, S_AOK);
    step(I_RRMOVQ, 4'd1, 64'h1234, rnd64(), rnd64(), 4'd3, S_AOK, S_AOK);
    #1 chk("cmovle not taken dstE", 64'(e_dstE), 64'hF);
    step(I_OPQ, 4'd3, 64'd9, 64'd9, rnd64(), 4'd2, S_AOK, S_AOK);
    step(I_RRMOVQ, 4'd1, 64'h1234, rnd64(), rnd64(), 4'd3, S_AOK, S_AOK);
    #1 chk("cmovle taken dstE", 64'(e_dstE), 64'd3);

    step(I_OPQ, 4'd0, 64'd5, 64'd7, rnd64(), 4'd2, S_AOK, S_AOK);
    step(I_OPQ, 4'd3, 64'd5, 64'd5, rnd64(), 4'd2, S_ADR, S_AOK);
    step(I_JXX, 4'd3, '0, '0, '0, 4'd1, S_AOK, S_AOK);
    #1 chk("ZF held after blocked xor", 64'(e_Cnd), 64'd0);
    step(I_OPQ, 4'd1, 64'd4, 64'd4, rnd64(), 4'd2, S_AOK, S_INS);
    step(I_OPQ, 4'd0, 64'd0, 64'd0, rnd64(), 4'd2, S_HLT, S_AOK);
    probe_cc();

    step(I_OPQ, 4'd7, 64'd3, 64'd3, rnd64(), 4'd2, S_AOK, S_AOK);
    step(I_OPQ, 4'd5, 64'd3, 64'd3, rnd64(), 4'd2, S_AOK, S_AOK);
`ifndef EXEC_MUL_EN
    step(I_OPQ, 4'd4, 64'd3, 64'd3, rnd64(), 4'd2, S_AOK, S_AOK);
`endif
    probe_cc();

    for (int i = 0; i < 300; i++) begin
      ic = 4'($urandom_range(0, 15));
      f  = 4'($urandom_range(0, 7));
`ifdef EXEC_MUL_EN
      if (ic == I_OPQ && f == F_MULQ) f = 4'd1;
`endif
      a = rnd64();
      b = rnd64();
      if ($urandom_range(0, 3) == 0) b = a;
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 3));
      ms = 4'($urandom_range(0, 5));
      ws = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 5)) : S_AOK;
      step(ic, f, a, b, rnd64(), 4'($urandom), ms, ws);
    end

`ifdef EXEC_MUL_EN
    @(negedge clk);
    E_icode = I_OPQ; E_ifun = F_MULQ; E_valA = 64'hFFFF_FFFF_FFFF_FFFD; E_valB = 64'd7;
    m_stat = S_AOK; W_stat = S_AOK;
    exp_prod = 64'($signed(E_valA) * $signed(E_valB));
    busy_n = 0; guard = 0;
    #1;
    while (e_busy === 1'b1 && guard < 200) begin
      busy_n++; guard++;
      @(negedge clk); #1;
    end
    chk("mul busy cycles", 64'(busy_n), 64'd65);
    chk("mul product", e_valE, exp_prod);
    chk("mul product const", e_valE, 64'hFFFF_FFFF_FFFF_FFEB);
    @(posedge clk);
    m_zf = (exp_prod == 64'd0); m_sf = ($signed(exp_prod) < 0); m_of = 1'b0;
    probe_cc();

    @(negedge clk);
    E_icode = I_OPQ; E_ifun = F_MULQ; E_valA = rnd64(); E_valB = rnd64();
    repeat (11) @(negedge clk);
    #1 chk("mul running before reset", 64'(e_busy), 64'd1);
    rst_n = 1'b0;
    #1 chk("busy drops on reset", 64'(e_busy), 64'd0);
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    E_icode = I_NOP; E_ifun = '0;
    @(negedge clk);
    rst_n = 1'b1;
    probe_cc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
